// File: rtl/xor_cell_arbiter_pkg.sv
// rtl/xor_cell_arbiter_pkg.sv - shared state encoding and latency helper for the xor cell arbiter
//
// Purpose : state enum for the arbiter FSM and the total per-operation latency,
//           used by both the RTL and the testbench.
// Contents: state_t    - IDLE, DRIVE, SETTLE, CAPTURE, DONE
//           total_latency(width, settle) - cycles from first grant cycle to done cycle
package xor_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Each bit costs one DRIVE cycle, SETTLE wait cycles and one CAPTURE cycle.
    function automatic int total_latency(input int width, input int settle);
        return width * (settle + 2);
    endfunction

endpackage

// File: rtl/xor_cell_arbiter_if.sv
// rtl/xor_cell_arbiter_if.sv - requester bus and cell drive signals of the xor cell arbiter
//
// Purpose : bundles the requester handshake, the operand buses, the result/status
//           outputs and the three wires to the shared cmos_xor cell.
// Signals : req[NREQ]          level request per requester
//           op_a/op_b[NREQ*W]  operand pairs, requester i at [i*WIDTH +: WIDTH]
//           gnt/done[NREQ]     one-hot grant and one-cycle completion pulse
//           result[W]          xor word, held until the next done
//           busy, err          FSM not idle / sticky cell mismatch
//           cell_a/cell_b      drive of the cmos_xor inputs, cell_y its output
// Modports: slave  - the arbiter side
//           master - the requester/cell side
interface xor_cell_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  busy;
    logic                  err;
    logic                  cell_a;
    logic                  cell_b;
    logic                  cell_y;

    modport slave (
        input  req, op_a, op_b, cell_y,
        output gnt, done, result, busy, err, cell_a, cell_b
    );

    modport master (
        output req, op_a, op_b, cell_y,
        input  gnt, done, result, busy, err, cell_a, cell_b
    );

endinterface

// File: rtl/xor_cell_arbiter_rr_pick.sv
// rtl/xor_cell_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose : selects the first set request bit searching upward from ptr, wrapping.
// Ports   : req[NREQ]     in  request vector
//           ptr[PW]       in  highest-priority index
//           win[NREQ]     out one-hot winner (zero when no request)
//           win_idx[PW]   out winner index (zero when no request)
//           any           out at least one request is set
module rr_pick
    import xor_ctrl_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    any
);

    localparam int PW = $clog2(NREQ);

    int w_idx;

    // Scan from the farthest offset down to offset 0 so the closest request
    // to ptr is the last one written and therefore the one that sticks.
    always_comb begin
        win     = '0;
        win_idx = '0;
        w_idx   = 0;
        any     = |req;
        for (int off = NREQ - 1; off >= 0; off--) begin
            w_idx = (int'(ptr) + off) % NREQ;
            if (req[w_idx]) begin
                win        = '0;
                win[w_idx] = 1'b1;
                win_idx    = PW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/xor_cell_arbiter.sv
// rtl/xor_cell_arbiter.sv - round-robin arbiter and bit-serial sequencer for one shared cmos_xor cell
//
// Purpose : grants one requester at a time, pushes its operand pair LSB first through
//           the 1-bit xor cell with SETTLE wait cycles per bit, returns the captured
//           word with a done pulse and flags any bit where the cell disagrees.
// Ports   : clk    in  clock
//           rst_n  in  synchronous active-low reset
//           bus    slave modport of xor_cell_arbiter_if (requests, operands, grant,
//                  done, result, busy, err, cell_a/cell_b/cell_y)
module xor_cell_arbiter
    import xor_ctrl_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    xor_cell_arbiter_if.slave  bus
);

    localparam int PW = $clog2(NREQ);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

    localparam logic [2:0] S_IDLE    = xor_ctrl_pkg::IDLE;
    localparam logic [2:0] S_DRIVE   = xor_ctrl_pkg::DRIVE;
    localparam logic [2:0] S_SETTLE  = xor_ctrl_pkg::SETTLE;
    localparam logic [2:0] S_CAPTURE = xor_ctrl_pkg::CAPTURE;
    localparam logic [2:0] S_DONE    = xor_ctrl_pkg::DONE;

    logic [2:0]       r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_w;
    logic [KW-1:0]    r_k;
    logic [CW-1:0]    r_cnt;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic             r_cell_a;
    logic             r_cell_b;

    logic [NREQ-1:0]  w_win;
    logic [PW-1:0]    w_win_idx;
    logic             w_any;
    logic [PW-1:0]    w_sel;
    logic [KW-1:0]    w_k_next;
    logic [WIDTH-1:0] w_a_word;
    logic [WIDTH-1:0] w_b_word;
    logic             w_drv_a;
    logic             w_drv_b;
    logic [WIDTH-1:0] w_cap;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (bus.req),
        .ptr     (r_ptr),
        .win     (w_win),
        .win_idx (w_win_idx),
        .any     (w_any)
    );

    // The next bit to drive: bit 0 of the new winner when leaving IDLE,
    // otherwise the following bit of the latched winner. Operands are read
    // at drive time, so a mid-operation operand change affects later bits only.
    always_comb begin
        w_sel    = (r_state == S_IDLE) ? w_win_idx : r_w;
        w_k_next = (r_state == S_IDLE) ? '0 : r_k + KW'(1);
        w_a_word = bus.op_a[int'(w_sel) * WIDTH +: WIDTH];
        w_b_word = bus.op_b[int'(w_sel) * WIDTH +: WIDTH];
        w_drv_a  = w_a_word[w_k_next];
        w_drv_b  = w_b_word[w_k_next];
        w_cap        = r_acc;
        w_cap[r_k]   = bus.cell_y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_w      <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_cell_a <= 1'b0;
            r_cell_b <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt    <= w_win;
                        r_w      <= w_win_idx;
                        r_k      <= '0;
                        r_cell_a <= w_drv_a;
                        r_cell_b <= w_drv_b;
                        r_state  <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_cnt   <= '0;
                    r_state <= (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_acc <= w_cap;
                    if (bus.cell_y != (r_cell_a ^ r_cell_b)) begin
                        r_err <= 1'b1;
                    end
                    if (r_k == K_LAST) begin
                        // w_cap already holds the last bit, so the word is
                        // complete in the done cycle itself.
                        r_result <= w_cap;
                        r_done   <= r_gnt;
                        r_cell_a <= 1'b0;
                        r_cell_b <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_k      <= w_k_next;
                        r_cell_a <= w_drv_a;
                        r_cell_b <= w_drv_b;
                        r_state  <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_gnt   <= '0;
                    r_ptr   <= (r_w == PTR_LAST) ? '0 : r_w + PW'(1);
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.err    = r_err;
    assign bus.cell_a = r_cell_a;
    assign bus.cell_b = r_cell_b;

endmodule

// File: tb/tb_xor_cell_arbiter.sv
// tb/tb_xor_cell_arbiter.sv - self-checking bench for xor_cell_arbiter
module tb_xor_cell_arbiter;
    import xor_ctrl_pkg::*;

    localparam int N    = 4;
    localparam int W0   = 8;
    localparam int S0   = 2;
    localparam int W1   = 4;
    localparam int S1   = 0;
    localparam int LAT0 = total_latency(W0, S0);
    localparam int LAT1 = total_latency(W1, S1);

    logic clk = 1'b0;
    logic rst_n;
    logic stuck;
    int   cyc_abs = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_ptr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    xor_cell_arbiter_if #(.NREQ(N), .WIDTH(W0)) if0 ();
    xor_cell_arbiter_if #(.NREQ(N), .WIDTH(W1)) if1 ();

    // Behavioural stand-ins for the cmos_xor cell; dut0's can be stuck at 0.
    assign if0.cell_y = stuck ? 1'b0 : (if0.cell_a ^ if0.cell_b);
    assign if1.cell_y = if1.cell_a ^ if1.cell_b;

    xor_cell_arbiter #(.NREQ(N), .WIDTH(W0), .SETTLE(S0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    xor_cell_arbiter #(.NREQ(N), .WIDTH(W1), .SETTLE(S1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    typedef struct {
        int         who;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Round-robin rule: first set request at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int off = 0; off < N; off++) begin
            if (m[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    task automatic set_op0(input int who, input logic [7:0] a, input logic [7:0] b);
        if0.op_a[who*W0 +: W0] = a;
        if0.op_b[who*W0 +: W0] = b;
    endtask

    // Waits for the grant of 'who' on dut0 and for its done pulse, checking latency,
    // result and err; drop_at > 0 deasserts req[who] that many cycles after the grant.
    task automatic run0(input int who, input logic [7:0] exp_r, input logic exp_err, input int drop_at);
        int cyc = 0;
        while (if0.gnt == '0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("gnt", 32'(if0.gnt), 32'(1) << who);
        check("busy_at_g", 32'(if0.busy), 32'(1));
        cyc = 0;
        while (if0.done == '0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == drop_at) if0.req[who] = 1'b0;
        end
        check("done_latency", 32'(cyc), 32'(LAT0));
        check("done", 32'(if0.done), 32'(1) << who);
        check("result", 32'(if0.result), 32'(exp_r));
        check("err", 32'(if0.err), 32'(exp_err));
        check("gnt_at_done", 32'(if0.gnt), 32'(1) << who);
        check("cell_a_at_done", 32'(if0.cell_a), 32'(0));
        if0.req[who] = 1'b0;
        m_ptr = (who + 1) % N;
        @(negedge clk);
        check("gnt_after_done", 32'(if0.gnt), 32'(0));
        check("done_after_done", 32'(if0.done), 32'(0));
        check("busy_after_done", 32'(if0.busy), 32'(0));
    endtask

    initial begin
        logic [7:0] ta [N];
        logic [7:0] tb_ [N];
        logic [3:0] a1 [2];
        logic [3:0] b1 [2];
        int         w1 [2];
        int         prev;
        int         cyc;
        int         w;
        logic [N-1:0] mask;

        tbl[0] = '{0, 8'hA5, 8'h3C, 8'h99};
        tbl[1] = '{1, 8'hFF, 8'hFF, 8'h00};
        tbl[2] = '{2, 8'h12, 8'h34, 8'h26};
        tbl[3] = '{3, 8'h80, 8'h01, 8'h81};
        tbl[4] = '{0, 8'h5A, 8'hC3, 8'h99};

        rst_n = 1'b0;
        stuck = 1'b0;
        if0.req = '0; if0.op_a = '0; if0.op_b = '0;
        if1.req = '0; if1.op_a = '0; if1.op_b = '0;
        repeat (3) @(negedge clk);

        check("rst_gnt", 32'(if0.gnt), 32'(0));
        check("rst_done", 32'(if0.done), 32'(0));
        check("rst_result", 32'(if0.result), 32'(0));
        check("rst_busy", 32'(if0.busy), 32'(0));
        check("rst_err", 32'(if0.err), 32'(0));
        check("rst_cell_a", 32'(if0.cell_a), 32'(0));
        check("rst_cell_b", 32'(if0.cell_b), 32'(0));
        check("rst_gnt1", 32'(if1.gnt), 32'(0));
        check("rst_busy1", 32'(if1.busy), 32'(0));

        // All four requesting from reset, held: grants 0,1,2,3,0 spaced LAT0+2.
        rst_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            ta[i]  = 8'((i + 1) * 8'h11);
            tb_[i] = 8'hF0;
            set_op0(i, ta[i], tb_[i]);
        end
        if0.req = 4'hF;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            w = pick(4'hF, m_ptr);
            cyc = 0;
            while (if0.done == '0 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("rr_done", 32'(if0.done), 32'(1) << w);
            check("rr_result", 32'(if0.result), 32'(ta[w] ^ tb_[w]));
            if (i > 0) check("rr_spacing", 32'(cyc_abs - prev), 32'(LAT0 + 2));
            prev = cyc_abs;
            m_ptr = (w + 1) % N;
            @(negedge clk);
        end
        if0.req = '0;
        @(negedge clk);

        // Single-request vector table.
        for (int i = 0; i < 5; i++) begin
            set_op0(tbl[i].who, tbl[i].a, tbl[i].b);
            if0.req[tbl[i].who] = 1'b1;
            run0(tbl[i].who, tbl[i].res, 1'b0, -1);
        end

        // SETTLE=0, WIDTH=4 instance.
        a1[0] = 4'hF; b1[0] = 4'h0; w1[0] = 0;
        a1[1] = 4'h6; b1[1] = 4'h3; w1[1] = 2;
        for (int j = 0; j < 2; j++) begin
            if1.op_a[w1[j]*W1 +: W1] = a1[j];
            if1.op_b[w1[j]*W1 +: W1] = b1[j];
            if1.req[w1[j]] = 1'b1;
            cyc = 0;
            while (if1.gnt == '0 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            check("s0_gnt", 32'(if1.gnt), 32'(1) << w1[j]);
            cyc = 0;
            while (if1.done == '0 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            check("s0_latency", 32'(cyc), 32'(LAT1));
            check("s0_result", 32'(if1.result), 32'(a1[j] ^ b1[j]));
            if1.req = '0;
            @(negedge clk);
        end

        // Request dropped 5 cycles after grant still completes; ptr then moves to 3.
        set_op0(2, 8'hC3, 8'h0F);
        if0.req[2] = 1'b1;
        run0(2, 8'hCC, 1'b0, 5);
        set_op0(0, 8'h01, 8'h02);
        set_op0(1, 8'h03, 8'h04);
        set_op0(3, 8'h70, 8'h07);
        if0.req = 4'b1011;
        w = pick(4'b1011, m_ptr);
        run0(w, 8'h77, 1'b0, -1);
        if0.req = '0;

        // Stuck-at-0 cell: err set and sticky until reset.
        stuck = 1'b1;
        set_op0(0, 8'h01, 8'h00);
        if0.req[0] = 1'b1;
        run0(0, 8'h00, 1'b1, -1);
        stuck = 1'b0;
        set_op0(1, 8'h0F, 8'h3C);
        if0.req[1] = 1'b1;
        run0(1, 8'h33, 1'b1, -1);
        rst_n = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(if0.err), 32'(0));
        rst_n = 1'b1;
        m_ptr = 0;

        // Reset mid-operation at g+10: no done, everything idle next cycle.
        set_op0(0, 8'hAA, 8'h55);
        if0.req[0] = 1'b1;
        cyc = 0;
        while (if0.gnt == '0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        if0.req = '0;
        @(negedge clk);
        check("midrst_gnt", 32'(if0.gnt), 32'(0));
        check("midrst_busy", 32'(if0.busy), 32'(0));
        check("midrst_done", 32'(if0.done), 32'(0));
        rst_n = 1'b1;
        m_ptr = 0;
        set_op0(1, 8'h0F, 8'h33);
        if0.req[1] = 1'b1;
        run0(1, 8'h3C, 1'b0, -1);

        // Randomized requests against the round-robin model.
        for (int it = 0; it < 20; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int r = 0; r < N; r++) begin
                ta[r]  = 8'($urandom);
                tb_[r] = 8'($urandom);
                set_op0(r, ta[r], tb_[r]);
            end
            if0.req = mask;
            w = pick(mask, m_ptr);
            run0(w, ta[w] ^ tb_[w], 1'b0, -1);
            if0.req = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_cell_arbiter.md
# xor_cell_arbiter

Round-robin arbiter and bit-serial sequencer that shares one switch-level `cmos_xor` cell among `NREQ` requesters. Each granted requester's `WIDTH`-bit operand pair is pushed through the 1-bit cell one bit per slot. Each bit waits `SETTLE` cycles for the transistor network to resolve, and the result word is then returned with a done pulse. The block also self-checks every captured bit and raises a sticky error on any mismatch. It sits between the requesting logic and the single `cmos_xor` instance, which it drives directly.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters (at least 2).
- `WIDTH`, default 8: operand and result width in bits.
- `SETTLE`, default 2: wait cycles per bit between driving the cell and capturing its output (0 is allowed).

Clocking: one clock; reset is synchronous and active-low.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst_n`, in, 1: synchronous active-low reset.
- `req`, in, `NREQ`: level request. Requester i holds `req[i]` high until its `done[i]`.
- `op_a`, in, `NREQ*WIDTH`: A operands. Requester i uses `[i*WIDTH +: WIDTH]`, which must be stable while `req[i]` is high.
- `op_b`, in, `NREQ*WIDTH`: B operands, same layout and stability rule as `op_a`.
- `gnt`, out, `NREQ`: one-hot grant, or all zero.
- `done`, out, `NREQ`: one-cycle completion pulse for the granted requester.
- `result`, out, `WIDTH`: XOR word. Valid in the done cycle and held until the next done.
- `busy`, out, 1: high whenever the state is not IDLE.
- `err`, out, 1: sticky cell-mismatch flag; only reset clears it.
- `cell_a`, out, 1: drives the A input of `cmos_xor`.
- `cell_b`, out, 1: drives the B input of `cmos_xor`.
- `cell_y`, in, 1: output of `cmos_xor`.

## Operation

Reset values: `gnt`=0, `done`=0, `result`=0, `busy`=0, `err`=0, `cell_a`=0, `cell_b`=0. Internally the state is IDLE, the pointer `ptr`=0, the bit index `k`=0 and the settle counter is 0.

State machine:
- IDLE
  - If `req` is nonzero, pick winner w, the first set bit searching upward from `ptr` and wrapping.
  - Register `gnt[w]`=1, latch w, set `k`=0, then go to DRIVE.
  - Otherwise stay in IDLE.
- DRIVE
  - Set `cell_a` = `op_a[w][k]` and `cell_b` = `op_b[w][k]`.
  - Clear the settle counter.
  - Go to SETTLE, or directly to CAPTURE if `SETTLE`=0.
- SETTLE
  - Increment the counter.
  - After exactly `SETTLE` cycles in this state, go to CAPTURE.
- CAPTURE
  - Store `result_r[k]` = `cell_y`.
  - If `cell_y` ≠ (`cell_a` ^ `cell_b`), set `err`.
  - If `k`=`WIDTH-1`, go to DONE. Otherwise increment `k` and go to DRIVE.
- DONE
  - Assert `done[w]`=1 and `result`=`result_r`, with `gnt[w]` still high.
  - Set `ptr` = (w+1) mod `NREQ`, then go to IDLE.

Cell drive rules:
- `cell_a` and `cell_b` hold their values from DRIVE through CAPTURE of the same bit.
- They are 0 in IDLE and in DONE.

Ordering and counter widths:
- Bits are processed LSB first.
- The result always records `cell_y`, even when it mismatches.
- The `k` counter is `$clog2(WIDTH)` bits wide; the settle counter is `$clog2(SETTLE+1)` bits wide (minimum 1).

## Timing

Let g be the first cycle in which `gnt[w]`=1, which is one cycle after IDLE samples `req`.
- Bit k occupies cycles g+k·(`SETTLE`+2) through g+k·(`SETTLE`+2)+`SETTLE`+1.
- `done[w]` is high in cycle g+`WIDTH`·(`SETTLE`+2). With the defaults this is g+32.
- `gnt` drops the cycle after done.
- The earliest next grant is 2 cycles after done, since IDLE takes one sampling cycle.

Boundary conditions:
- **Simultaneous requests:** round-robin from `ptr`. A requester that keeps `req` high cannot win twice while another is waiting.
- **Requests during an operation:** ignored until IDLE; no preemption.
- **`req[w]` dropped mid-operation:** the operation still completes and `done[w]` still pulses.
- **Operand change mid-operation:** bits not yet driven use the new value. This is a protocol violation and is not checked.
- **`rst_n` low mid-operation:** all reset values apply on the next edge, with no done pulse.
- **`ptr` wrap-around:** after w=`NREQ-1`, `ptr` returns to 0.

## Structure

- Package `xor_ctrl_pkg`:
  - State enum `{IDLE, DRIVE, SETTLE, CAPTURE, DONE}`.
  - Function giving total latency `WIDTH*(SETTLE+2)`, shared with the testbench.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs `req`, `ptr`.
  - Outputs one-hot `win`, index `win_idx`, and `any`.
- The top level contains the FSM, counters and result register, and instantiates `cmos_xor` only in the testbench wrapper.

## Test plan

1. **Single request:** `req`=0001, A0=0xA5, B0=0x3C, defaults → `gnt`=0001 at g, `done`=0001 at g+32, `result`=0x99, `err`=0.
2. **All four requesting from reset:** `req`=1111 held → grants in order 0,1,2,3,0. `done` pulses are spaced 34 cycles apart.
3. **`SETTLE`=0, `WIDTH`=4:** A=0xF, B=0x0 → done at g+8, `result`=0xF.
4. **Stuck-at-0 cell:** replace the cell with constant-0 `cell_y`, A=0x01, B=0x00 → `result`=0x00 and `err`=1, staying 1 across later correct operations until `rst_n`=0.
5. **Reset mid-operation:** `rst_n` low for 1 cycle at g+10 → next cycle `gnt`=0, `busy`=0, no done. A fresh request then completes normally.
6. **Request dropped early:** `req[2]` deasserted at g+5 → `done[2]` still pulses at g+32 and `ptr` advances to 3.
